// File: rtl/music_player.sv
// Melody sequencer: plays a host-written table of {half_period, beats} notes
// as a square wave on music_play, once or looping.
// Optional inter-note silent gap is enabled by defining MUSIC_GAP_EN.
module music_player #(
    parameter int unsigned DIV_W      = 18,
    parameter int unsigned BEAT_W     = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned BEAT_DIV   = 12_500_000,
    parameter int unsigned GAP_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DIV_W+BEAT_W-1:0]  wr_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic                     music_play,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] note_idx
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DIV_W + BEAT_W;
    localparam int unsigned PW = $clog2(BEAT_DIV + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlay
`ifdef MUSIC_GAP_EN
        , StGap
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DIV_W-1:0]  hp_q, hp_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              play_q, play_d;
    logic              done_q, done_d;

    logic [EW-1:0]     table_q [DEPTH];
    logic [EW-1:0]     entry;
    logic [DIV_W-1:0]  entry_hp;
    logic [BEAT_W-1:0] entry_beats;

    logic              advance;
    logic              song_end;

`ifdef MUSIC_GAP_EN
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0]     gap_q, gap_d;
`else
    logic              unused_gap_cfg;
    assign unused_gap_cfg = ^GAP_CYCLES;
`endif

    // Note table: host-writable at any time, contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    assign entry       = table_q[idx_q];
    assign entry_hp    = entry[EW-1:BEAT_W];
    assign entry_beats = entry[BEAT_W-1:0];

    // State and working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            hp_q    <= '0;
            beats_q <= '0;
            div_q   <= '0;
            pre_q   <= '0;
            play_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hp_q    <= hp_d;
            beats_q <= beats_d;
            div_q   <= div_d;
            pre_q   <= pre_d;
            play_q  <= play_d;
            done_q  <= done_d;
        end
    end

`ifdef MUSIC_GAP_EN
    // Gap length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    // Next-state logic: sequencing, tone divider, beat prescaler.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hp_d     = hp_q;
        beats_d  = beats_q;
        div_d    = div_q;
        pre_d    = pre_q;
        play_d   = play_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        song_end = 1'b0;
`ifdef MUSIC_GAP_EN
        gap_d    = gap_q;
`endif

        case (state_q)
            StIdle: begin
                idx_d   = '0;
                beats_d = '0;
                div_d   = '0;
                pre_d   = '0;
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                hp_d    = entry_hp;
                beats_d = entry_beats;
                div_d   = '0;
                pre_d   = '0;
                play_d  = 1'b0;
                if (entry_beats == '0) begin
                    song_end = 1'b1;
                end else begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                // A zero half-period is a rest: output stays low.
                if (hp_q != '0) begin
                    if (div_q == hp_q - DIV_W'(1)) begin
                        play_d = ~play_q;
                        div_d  = '0;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end else begin
                    play_d = 1'b0;
                end
                if (pre_q == PW'(BEAT_DIV - 1)) begin
                    pre_d = '0;
                    if (beats_q == BEAT_W'(1)) begin
`ifdef MUSIC_GAP_EN
                        state_d = StGap;
                        gap_d   = '0;
`else
                        advance = 1'b1;
`endif
                    end else begin
                        beats_d = beats_q - BEAT_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
`ifdef MUSIC_GAP_EN
            StGap: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    advance = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // The last table slot ends the song without reading a marker.
        if (advance) begin
            if (idx_q == AW'(DEPTH - 1)) begin
                song_end = 1'b1;
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = StLoad;
            end
        end

        if (song_end) begin
            idx_d = '0;
            if (loop_en) begin
                state_d = StLoad;
            end else begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end

        // Abort wins over everything, including start and song end.
        if (stop) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b0;
        end

        // Output is silent outside PLAY.
        if (state_d != StPlay) begin
            play_d = 1'b0;
        end
    end

    assign music_play = play_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign note_idx   = idx_q;

endmodule

// File: doc/music_player.md
# music_player

Parametrised melody sequencer that drives the speaker output `music_play` with a square wave. A host writes a song of up to DEPTH note entries into an internal table; each entry gives a half-period in clock cycles and a length in beats. On `start` the block plays the entries in order, once or looping. It replaces the fixed single-tone music block and sits between the game/control FSM and the audio pin.

## Interface
- `DIV_W`, 18, width of the half-period field in cycles; max tone half-period is 2^DIV_W-1.
- `BEAT_W`, 4, width of the beat-count field per note.
- `DEPTH`, 16, number of note entries; power of two, at least 2.
- `BEAT_DIV`, 12_500_000, clock cycles per beat; must be at least 1.
- `GAP_CYCLES`, 1_000_000, silent gap between notes; used only with MUSIC_GAP_EN.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  writes `wr_data` to `wr_addr` on this cycle.
- `wr_addr`  in  $clog2(DEPTH)  table index to write.
- `wr_data`  in  DIV_W+BEAT_W  note entry, {half_period, beats}.
- `start`  in  1  level-sampled; starts playback from index 0 when the block is idle.
- `stop`  in  1  aborts playback immediately.
- `loop_en`  in  1  sampled at end of song; 1 restarts the song at index 0.
- `music_play`  out  1  square-wave audio output.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a non-looping song finishes.
- `note_idx`  out  $clog2(DEPTH)  index of the current entry.

## Operation
- The table is DEPTH x (DIV_W+BEAT_W) registers.
  - It is writable at any time.
  - A write to the entry being played takes effect at that entry's next LOAD.
  - Table contents are not reset.
- **Entry meaning**
  - `half_period` = 0 means a rest: output held at 0 for the note's length.
  - `beats` = 0 is an end-of-song marker.
- **States:** IDLE, LOAD, PLAY, GAP (gap state only with MUSIC_GAP_EN).
- **IDLE**
  - Outputs: `music_play`=0, `note_idx`=0.
  - `start`=1 and `stop`=0 → go to LOAD.
- **LOAD**
  - Latches entry[note_idx] into the working half-period and beat registers.
  - Clears the divider counter, the beat prescaler and `music_play`.
  - If beats=0: song ends (see end-of-song rule). Otherwise go to PLAY.
- **PLAY**
  - Divider counts 0..half_period-1. At terminal count it toggles `music_play` and wraps, giving a period of 2·half_period cycles.
  - Prescaler counts 0..BEAT_DIV-1. At each wrap the remaining-beat count decrements.
  - When the last beat's terminal count is reached, the note ends.
- **Note end**
  - Without gap: go to LOAD with note_idx+1.
  - With MUSIC_GAP_EN: go to GAP first (see Configuration).
  - If note_idx=DEPTH-1, the song ends instead of advancing.
- **End-of-song rule**
  - `loop_en`=1: note_idx←0, go to LOAD.
  - `loop_en`=0: pulse `done`, go to IDLE.
- **Priorities**
  - `stop` in any state → IDLE on the next edge; no `done` pulse. `stop` beats `start` in the same cycle.
  - `start` is ignored while busy.

## Timing
- **Reset values:** state IDLE; `music_play`=0, `busy`=0, `done`=0, `note_idx`=0; all counters 0.
- **Start:** `start` high at edge N → LOAD at N+1, PLAY at N+2.
- **First toggle:** occurs half_period cycles after entering PLAY.
- **Note length:** PLAY lasts exactly beats·BEAT_DIV cycles; one extra LOAD cycle between notes.
- **Done:** asserted in the cycle IDLE is entered, for exactly one cycle. `busy` falls on that same edge.
- **Counter widths:**
  - Divider is DIV_W bits.
  - Prescaler is $clog2(BEAT_DIV+1) bits.
  - Beat counter is BEAT_W bits.
  - None wraps outside its terminal compare.
- **Reset mid-play:** asynchronous return to the reset values above. The output is silenced immediately.

## Configuration
- **MUSIC_GAP_EN defined**
  - After each note, GAP holds `music_play`=0 for GAP_CYCLES cycles, then goes to LOAD or applies the end-of-song rule.
  - `stop` during GAP → IDLE.
- **MUSIC_GAP_EN undefined**
  - No GAP state and no gap counter; notes run back to back.
  - GAP_CYCLES is unused.

## Test plan
Test parameters: DIV_W=4, BEAT_W=2, DEPTH=4, BEAT_DIV=8, GAP_CYCLES=3.

- **Single note:** write entry0={3,2}, entry1={0,0}, start pulse, loop_en=0.
  - `music_play` toggles every 3 cycles for 16 PLAY cycles.
  - Then LOAD of entry1 and a `done` pulse; `busy` high from the start edge until the `done` edge.
- **Rest and full table:** entries {2,1},{0,1},{5,1},{1,1}.
  - Rest entry gives `music_play`=0 for 8 cycles.
  - After index 3, `done` pulses.
  - `note_idx` sequence is 0,1,2,3.
- **Looping:** same song with loop_en=1.
  - After entry3, `note_idx` returns to 0 and no `done` pulse occurs.
  - Drop loop_en → `done` at the next song end.
- **Stop and priority:**
  - `stop` mid-PLAY → `music_play`=0 and IDLE on the next cycle, no `done`.
  - `start` and `stop` in the same cycle → remains IDLE.
- **Async reset:** assert rst_n=0 mid-note, off the clock edge.
  - Outputs go to the reset values immediately.
  - After release, a start replays from index 0.
- **MUSIC_GAP_EN:** two notes {3,1},{3,1}.
  - A 3-cycle zero gap appears between the notes.
  - Each note transition takes 3+1 cycles beyond the 8 beat cycles.
